// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite command master: response codes and FSM states.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: turns one command into one AXI read or write
// and returns the captured response. All AXI-facing outputs come from state/registers.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,

    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    BVALID,
    output logic                    BREADY,
    input  logic [1:0]              BRESP,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    RVALID,
    output logic                    RREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP
);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;
    logic                    write_q;
    logic                    aw_done, w_done;

    logic accept, aw_fire, w_fire, aw_all, w_all;

    assign accept  = cmd_valid && cmd_ready;
    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;
    // A channel counts as finished if it completed earlier or completes this cycle.
    assign aw_all  = aw_done || aw_fire;
    assign w_all   = w_done || w_fire;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (accept) state_nxt = cmd_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                AWVALID = !aw_done;
                WVALID  = !w_done;
                if (aw_all && w_all) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) state_nxt = RSP;
            end
            RD_REQ: begin
                ARVALID = 1'b1;
                if (ARREADY) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                RREADY = 1'b1;
                if (RVALID) state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            write_q <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    addr_q  <= cmd_addr;
                    wdata_q <= cmd_wdata;
                    wstrb_q <= cmd_wstrb;
                    write_q <= cmd_write;
                    rdata_q <= '0;
                    resp_q  <= RESP_OKAY;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                WR_REQ: begin
                    // Flags are cleared on exit so the next write starts fresh.
                    aw_done <= aw_all && !w_all;
                    w_done  <= w_all && !aw_all;
                end
                WR_RESP: if (BVALID) resp_q <= BRESP;
                RD_DATA: if (RVALID) begin
                    rdata_q <= RDATA;
                    resp_q  <= RRESP;
                end
                default: ;
            endcase
        end
    end

    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: table of commands against a delay-configurable AXI-Lite
// slave model, responses checked through a scoreboard queue, plus a mid-read reset.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        AWVALID, AWREADY = 1'b0, WVALID, WREADY = 1'b0;
    logic [7:0]  AWADDR, ARADDR;
    logic [31:0] WDATA, RDATA = '0;
    logic [3:0]  WSTRB;
    logic        BVALID = 1'b0, BREADY, ARVALID, ARREADY = 1'b0, RVALID = 1'b0, RREADY;
    logic [1:0]  BRESP = '0, RRESP = '0;

    axi_lite_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: all decisions made at negedge, so a ready/valid raised here is
    // guaranteed to meet the DUT's registered valid/ready at the following posedge.
    int          cur_aw_dly = 0, cur_w_dly = 0, cur_ar_dly = 0, cur_r_dly = 0;
    logic [1:0]  cur_resp = 2'd0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_count = 0;
    logic        aw_hs = 0, w_hs = 0, ar_hs = 0, b_fire = 0, r_fire = 0;
    logic [7:0]  sl_awaddr = '0, sl_araddr = '0;
    logic [31:0] sl_wdata = '0;
    logic [3:0]  sl_wstrb = '0;
    logic [31:0] mem [0:63] = '{default: 32'h0};

    always @(negedge clk) begin
        if (rst) begin
            AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
            aw_hs = 0; w_hs = 0; ar_hs = 0; b_fire = 0; r_fire = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (AWREADY) begin AWREADY = 0; aw_hs = 1; end
            else if (AWVALID && !aw_hs) begin
                if (aw_cnt >= cur_aw_dly) begin AWREADY = 1; aw_cnt = 0; sl_awaddr = AWADDR; end
                else aw_cnt++;
            end
            if (WREADY) begin WREADY = 0; w_hs = 1; end
            else if (WVALID && !w_hs) begin
                if (w_cnt >= cur_w_dly) begin WREADY = 1; w_cnt = 0; sl_wdata = WDATA; sl_wstrb = WSTRB; end
                else w_cnt++;
            end
            if (ARREADY) begin ARREADY = 0; ar_hs = 1; end
            else if (ARVALID && !ar_hs) begin
                if (ar_cnt >= cur_ar_dly) begin ARREADY = 1; ar_cnt = 0; sl_araddr = ARADDR; end
                else ar_cnt++;
            end
            if (b_fire) begin BVALID = 0; b_fire = 0; b_count++; end
            if (aw_hs && w_hs && !BVALID) begin
                if (cur_resp == 2'd0)
                    for (int i = 0; i < 4; i++)
                        if (sl_wstrb[i]) mem[sl_awaddr[7:2]][8*i +: 8] = sl_wdata[8*i +: 8];
                BRESP = cur_resp; BVALID = 1; aw_hs = 0; w_hs = 0;
            end
            if (BVALID && BREADY) b_fire = 1;
            if (r_fire) begin RVALID = 0; r_fire = 0; end
            if (ar_hs && !RVALID) begin
                if (r_cnt >= cur_r_dly) begin
                    RDATA = (cur_resp == 2'd0) ? mem[sl_araddr[7:2]] : 32'h0;
                    RRESP = cur_resp; RVALID = 1; ar_hs = 0; r_cnt = 0;
                end else r_cnt++;
            end
            if (RVALID && RREADY) r_fire = 1;
        end
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly, w_dly, ar_dly, r_dly, rsp_dly;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        int          exp_lat, exp_aw_cyc, exp_w_cyc;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    vec_t vecs [0:9];
    exp_t sb [$];

    task automatic run_vec(input int id, input vec_t v);
        int   k, first, hold, aw_cyc, w_cyc, b_before;
        bit   got, seen, overlap, aw_bad, hold_bad;
        exp_t e;
        string tag;
        tag = $sformatf("v%0d", id);
        cur_aw_dly = v.aw_dly; cur_w_dly = v.w_dly;
        cur_ar_dly = v.ar_dly; cur_r_dly = v.r_dly; cur_resp = v.resp;
        b_before = b_count;
        aw_cyc = 0; w_cyc = 0; overlap = 0; aw_bad = 0; hold_bad = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (cmd_ready) seen = 1;
            else @(negedge clk);
        end
        if (!seen) begin
            errors++; checks++;
            $display("FAIL %s_accept: cmd_ready never rose", tag);
            cmd_valid = 0;
            return;
        end
        k = cyc;
        sb.push_back('{v.wr, v.wr ? 32'h0 : v.exp_rdata, v.resp});
        @(posedge clk); #1 cmd_valid = 0;
        got = 0; first = -1; hold = 0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (AWVALID) begin aw_cyc++; if (AWADDR !== v.addr) aw_bad = 1; end
            if (WVALID) w_cyc++;
            if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)) overlap = 1;
            if (rsp_valid) begin
                if (first < 0) first = cyc;
                if (hold < v.rsp_dly) begin
                    rsp_ready = 0; hold++;
                    if (rsp_resp !== v.resp || cmd_ready !== 1'b0) hold_bad = 1;
                end else begin
                    rsp_ready = 1; got = 1;
                    e = sb.pop_front();
                    check({tag, "_rsp_write"}, 32'(rsp_write), 32'(e.wr));
                    check({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
                    check({tag, "_rsp_resp"}, 32'(rsp_resp), 32'(e.resp));
                end
            end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL %s_timeout: no response within budget", tag);
        end
        @(posedge clk); #1 rsp_ready = 0;
        if (v.exp_lat > 0) check({tag, "_latency"}, 32'(first - k), 32'(v.exp_lat));
        if (v.exp_aw_cyc > 0) check({tag, "_awvalid_cycles"}, 32'(aw_cyc), 32'(v.exp_aw_cyc));
        if (v.exp_w_cyc > 0) check({tag, "_wvalid_cycles"}, 32'(w_cyc), 32'(v.exp_w_cyc));
        if (v.wr) begin
            check({tag, "_awaddr_stable"}, 32'(aw_bad), 32'h0);
            check({tag, "_b_accepted"}, 32'(b_count - b_before), 32'h1);
        end
        if (v.rsp_dly > 0) check({tag, "_rsp_hold"}, 32'(hold_bad), 32'h0);
        check({tag, "_channel_overlap"}, 32'(overlap), 32'h0);
    endtask

    initial begin
        //          wr addr   wdata         strb aw w  ar r  rsp resp  exp_rdata     lat awc wc
        vecs[0] = '{1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'd0, 32'h0,        3, 1, 1};
        vecs[1] = '{0, 8'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 32'hDEADBEEF, 3, 0, 0};
        vecs[2] = '{1, 8'h14, 32'h12345678, 4'hF, 3, 0, 0, 0, 0, 2'd0, 32'h0,        0, 4, 1};
        vecs[3] = '{1, 8'h14, 32'hAABBCCDD, 4'h5, 0, 2, 0, 0, 0, 2'd0, 32'h0,        0, 1, 3};
        vecs[4] = '{0, 8'h14, 32'h0,        4'h0, 0, 0, 2, 1, 0, 2'd0, 32'h12BB56DD, 0, 0, 0};
        vecs[5] = '{1, 8'h20, 32'h11111111, 4'hF, 0, 0, 0, 0, 2, 2'd2, 32'h0,        3, 1, 1};
        vecs[6] = '{0, 8'h20, 32'h0,        4'h0, 0, 0, 0, 0, 5, 2'd2, 32'h0,        3, 0, 0};
        vecs[7] = '{0, 8'h14, 32'h0,        4'h0, 0, 0, 1, 2, 1, 2'd3, 32'h0,        0, 0, 0};
        vecs[8] = '{1, 8'h18, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 2'd0, 32'h0,        3, 1, 1};
        vecs[9] = '{0, 8'h18, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 32'hCAFEF00D, 3, 0, 0};

        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_axi_valids", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'h0);
        check("reset_rsp_fields", {rsp_rdata[29:0], rsp_resp}, 32'h0);
        rst = 0;
        @(negedge clk);
        check("post_reset_cmd_ready", 32'(cmd_ready), 32'h1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while a read address is waiting for ARREADY: abandoned, no response.
        cur_ar_dly = 1000; cur_resp = 2'd0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h10;
        check("midrst_accept_ready", 32'(cmd_ready), 32'h1);
        @(posedge clk); #1 cmd_valid = 0;
        repeat (3) @(negedge clk);
        check("midrst_arvalid_waiting", 32'(ARVALID), 32'h1);
        rst = 1;
        @(negedge clk);
        check("midrst_arvalid_dropped", 32'(ARVALID), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_cmd_ready_in_reset", 32'(cmd_ready), 32'h0);
        rst = 0;
        @(negedge clk);
        check("midrst_cmd_ready_after", 32'(cmd_ready), 32'h1);
        check("midrst_rsp_valid_after", 32'(rsp_valid), 32'h0);

        run_vec(8, vecs[8]);
        run_vec(9, vecs[9]);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
